// File: rtl/count_event_monitor.sv
// Monitors an up/down counter's output, classifies each transition (wrap, step error, stall)
// and queues event records in a small FIFO drained through a valid/ready handshake.
module count_event_monitor #(
  parameter int W         = 4,
  parameter int DEPTH     = 4,
  parameter int STALL_LIM = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] cnt_in,
  input  logic         dir,
  input  logic         cnt_en,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic [1:0]   evt_code,
  output logic [W-1:0] evt_value,
  output logic [7:0]   wrap_cnt,
  output logic         overflow,
  input  logic         clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0]    CODE_WRAP_UP  = 2'b00;
  localparam logic [1:0]    CODE_WRAP_DN  = 2'b01;
  localparam logic [1:0]    CODE_STEP_ERR = 2'b10;
  localparam logic [1:0]    CODE_STALL    = 2'b11;
  localparam logic [W-1:0]  VAL_MAX       = {W{1'b1}};
  localparam logic [W-1:0]  VAL_ZERO      = {W{1'b0}};
  localparam logic [7:0]    STALL_MAX     = 8'(STALL_LIM);
  localparam logic [AW:0]   FULL_CNT      = (AW+1)'(DEPTH);
  localparam logic [AW:0]   EMPTY_CNT     = {(AW+1){1'b0}};

  logic [W-1:0]  prev_r;
  logic          primed_r;
  logic [7:0]    stall_r;
  logic [1:0]    mem_code_r  [DEPTH];
  logic [W-1:0]  mem_value_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          valid_r;
  logic [7:0]    wrap_cnt_r;
  logic          overflow_r;

  logic [W-1:0]  exp_s;
  logic          same_s;
  logic          evt_s;
  logic          wrap_s;
  logic [1:0]    code_s;
  logic [7:0]    stall_nxt_s;
  logic [7:0]    wrap_nxt_s;
  logic          pop_s;
  logic          full_s;
  logic          push_s;
  logic          drop_s;
  logic [AW:0]   count_nxt_s;

  // Transition classification and stall run-length tracking
  always_comb begin
    evt_s       = 1'b0;
    wrap_s      = 1'b0;
    code_s      = CODE_WRAP_UP;
    stall_nxt_s = stall_r;
    if (dir) exp_s = prev_r + W'(1);
    else     exp_s = prev_r - W'(1);
    same_s = (cnt_in == prev_r);
    if (!primed_r) begin
      stall_nxt_s = 8'd0;
    end else if (same_s) begin
      // Saturating at the limit keeps a long stall from re-firing.
      if (cnt_en && (stall_r < STALL_MAX)) begin
        stall_nxt_s = stall_r + 8'd1;
        if (stall_r == STALL_MAX - 8'd1) begin
          evt_s  = 1'b1;
          code_s = CODE_STALL;
        end else begin
          evt_s  = 1'b0;
        end
      end else begin
        stall_nxt_s = stall_r;
      end
    end else begin
      stall_nxt_s = 8'd0;
      if (cnt_in != exp_s) begin
        evt_s  = 1'b1;
        code_s = CODE_STEP_ERR;
      end else if (dir && (prev_r == VAL_MAX)) begin
        evt_s  = 1'b1;
        wrap_s = 1'b1;
        code_s = CODE_WRAP_UP;
      end else if (!dir && (prev_r == VAL_ZERO)) begin
        evt_s  = 1'b1;
        wrap_s = 1'b1;
        code_s = CODE_WRAP_DN;
      end else begin
        evt_s  = 1'b0;
      end
    end
  end

  // FIFO push/pop/drop decisions and saturating wrap tally
  always_comb begin
    pop_s       = valid_r & evt_ready;
    full_s      = (count_r == FULL_CNT);
    push_s      = evt_s & (~full_s | pop_s);
    drop_s      = evt_s & full_s & ~pop_s;
    count_nxt_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    if (wrap_s && (wrap_cnt_r != 8'hFF)) wrap_nxt_s = wrap_cnt_r + 8'd1;
    else                                 wrap_nxt_s = wrap_cnt_r;
  end

  // State registers: sampling, stall counter, FIFO storage and status flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_r     <= VAL_ZERO;
      primed_r   <= 1'b0;
      stall_r    <= 8'd0;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= EMPTY_CNT;
      valid_r    <= 1'b0;
      wrap_cnt_r <= 8'd0;
      overflow_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_code_r[i]  <= 2'b00;
        mem_value_r[i] <= VAL_ZERO;
      end
    end else begin
      prev_r     <= cnt_in;
      primed_r   <= 1'b1;
      stall_r    <= stall_nxt_s;
      count_r    <= count_nxt_s;
      valid_r    <= (count_nxt_s != EMPTY_CNT);
      wrap_cnt_r <= wrap_nxt_s;
      if (push_s) begin
        mem_code_r[wr_ptr_r]  <= code_s;
        mem_value_r[wr_ptr_r] <= cnt_in;
        wr_ptr_r              <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop_s)       overflow_r <= 1'b1;
      else if (clr_ovf) overflow_r <= 1'b0;
      else              overflow_r <= overflow_r;
    end
  end

  assign evt_valid = valid_r;
  assign evt_code  = mem_code_r[rd_ptr_r];
  assign evt_value = mem_value_r[rd_ptr_r];
  assign wrap_cnt  = wrap_cnt_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_count_event_monitor.sv
// Self-checking bench for count_event_monitor: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_count_event_monitor;
  localparam int W = 4;
  localparam int DEPTH = 4;
  localparam int LIM = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic [3:0] cnt_in = 4'd0;
  logic       dir = 1'b1;
  logic       cnt_en = 1'b0;
  logic       evt_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic [3:0] evt_value;
  logic [7:0] wrap_cnt;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] code;
    logic [3:0] value;
  } evt_t;

  evt_t mq[$];
  int   m_prev = 0;
  int   m_stall = 0;
  int   m_wrap = 0;
  bit   m_primed = 1'b0;
  bit   m_ovf = 1'b0;

  count_event_monitor #(.W(W), .DEPTH(DEPTH), .STALL_LIM(LIM)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .dir(dir), .cnt_en(cnt_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_value(evt_value), .wrap_cnt(wrap_cnt), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  // Reference model: what the monitor should do at the coming edge for these inputs.
  task automatic model_edge(input bit r, input int c, input bit d, input bit e,
                            input bit rdy, input bit clr);
    bit   has = 1'b0;
    bit   is_wrap = 1'b0;
    bit   drop = 1'b0;
    evt_t ev;
    int   diff;
    if (!r) begin
      mq.delete();
      m_primed = 1'b0; m_stall = 0; m_wrap = 0; m_ovf = 1'b0; m_prev = 0;
      return;
    end
    ev.value = 4'(c);
    ev.code  = 2'b00;
    if (m_primed) begin
      diff = (c - m_prev + 16) % 16;
      if (diff == 0) begin
        if (e && m_stall < LIM) begin
          m_stall++;
          if (m_stall == LIM) begin has = 1'b1; ev.code = 2'b11; end
        end
      end else begin
        m_stall = 0;
        if (d && diff == 1) begin
          if (m_prev == 15) begin has = 1'b1; is_wrap = 1'b1; ev.code = 2'b00; end
        end else if (!d && diff == 15) begin
          if (m_prev == 0) begin has = 1'b1; is_wrap = 1'b1; ev.code = 2'b01; end
        end else begin
          has = 1'b1; ev.code = 2'b10;
        end
      end
    end
    m_prev = c;
    m_primed = 1'b1;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (has) begin
      if (is_wrap && m_wrap < 255) m_wrap++;
      if (mq.size() < DEPTH) mq.push_back(ev);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic drive(input bit r, input int c, input bit d, input bit e,
                       input bit rdy, input bit clr);
    reset = r; cnt_in = 4'(c); dir = d; cnt_en = e; evt_ready = rdy; clr_ovf = clr;
    model_edge(r, c, d, e, rdy, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input int v, input bit d);
    drive(1'b0, v, d, 1'b1, 1'b1, 1'b0);
    drive(1'b1, v, d, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 9, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (evt_valid !== 1'b0 || evt_code !== 2'b00 || evt_value !== 4'd0 ||
        wrap_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b c=%0d val=%0d wrap=%0d ovf=%0b, want all 0",
               evt_valid, evt_code, evt_value, wrap_cnt, overflow);
    end
  endtask

  task automatic test_wrap_up();
    restart(0, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      drive(1'b1, i, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (evt_valid !== 1'b0) begin
        errors++; $display("FAIL wrap_up_quiet: step %0d valid=%0b, want 0", i, evt_valid);
      end
    end
    drive(1'b1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'b00 || evt_value !== 4'd0 || wrap_cnt !== 8'd1) begin
      errors++;
      $display("FAIL wrap_up_evt: got v=%0b c=%0d val=%0d wrap=%0d, want v=1 c=0 val=0 wrap=1",
               evt_valid, evt_code, evt_value, wrap_cnt);
    end
    drive(1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_up_single: valid=%0b after pop, want 0", evt_valid);
    end
  endtask

  task automatic test_wrap_down();
    int seq[4] = '{2, 1, 0, 15};
    restart(3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i], 1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (i < 3 && evt_valid !== 1'b0) begin
        errors++; $display("FAIL wrap_dn_quiet: step %0d valid=%0b, want 0", i, evt_valid);
      end else if (i == 3 && (evt_valid !== 1'b1 || evt_code !== 2'b01 ||
                              evt_value !== 4'd15 || wrap_cnt !== 8'd1)) begin
        errors++;
        $display("FAIL wrap_dn_evt: got v=%0b c=%0d val=%0d wrap=%0d, want v=1 c=1 val=15 wrap=1",
                 evt_valid, evt_code, evt_value, wrap_cnt);
      end
    end
  endtask

  task automatic test_step_error();
    restart(5, 1'b1);
    drive(1'b1, 9, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'b10 || evt_value !== 4'd9) begin
      errors++;
      $display("FAIL step_err_up: got v=%0b c=%0d val=%0d, want v=1 c=2 val=9",
               evt_valid, evt_code, evt_value);
    end
    drive(1'b1, 9, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL step_err_pop: valid=%0b, want 0", evt_valid);
    end
    drive(1'b1, 10, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'b10 || evt_value !== 4'd10) begin
      errors++;
      $display("FAIL step_err_dn: got v=%0b c=%0d val=%0d, want v=1 c=2 val=10",
               evt_valid, evt_code, evt_value);
    end
  endtask

  task automatic test_stall();
    restart(7, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1, 7, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (evt_valid !== (i == LIM) || (i == LIM && (evt_code !== 2'b11 || evt_value !== 4'd7))) begin
        errors++;
        $display("FAIL stall_7: sample %0d got v=%0b c=%0d val=%0d, want v=%0b c=3 val=7",
                 i, evt_valid, evt_code, evt_value, i == LIM);
      end
    end
    drive(1'b1, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= LIM; i++) begin
      drive(1'b1, 8, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (evt_valid !== (i == LIM) || (i == LIM && (evt_code !== 2'b11 || evt_value !== 4'd8))) begin
        errors++;
        $display("FAIL stall_8: sample %0d got v=%0b c=%0d val=%0d, want v=%0b c=3 val=8",
                 i, evt_valid, evt_code, evt_value, i == LIM);
      end
    end
  endtask

  task automatic test_overflow();
    int inj[5] = '{5, 10, 3, 8, 13};
    int exp_drain[4] = '{10, 3, 8, 2};
    restart(0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, inj[i], 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (evt_valid !== 1'b1 || evt_code !== 2'b10 || evt_value !== 4'd5 || overflow !== (i == 4)) begin
        errors++;
        $display("FAIL ovf_fill: inj %0d got v=%0b c=%0d val=%0d ovf=%0b, want v=1 c=2 val=5 ovf=%0b",
                 i, evt_valid, evt_code, evt_value, overflow, i == 4);
      end
    end
    drive(1'b1, 13, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0 || evt_value !== 4'd5) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%0b head=%0d, want ovf=0 head=5", overflow, evt_value);
    end
    // Push while full with a simultaneous pop must not drop.
    drive(1'b1, 2, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (overflow !== 1'b0 || evt_value !== 4'd10) begin
      errors++;
      $display("FAIL full_push_pop: got ovf=%0b head=%0d, want ovf=0 head=10", overflow, evt_value);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_value !== 4'(exp_drain[k])) begin
        errors++;
        $display("FAIL drain_order: entry %0d got v=%0b val=%0d, want v=1 val=%0d",
                 k, evt_valid, evt_value, exp_drain[k]);
      end
      drive(1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: valid=%0b, want 0", evt_valid);
    end
  endtask

  task automatic test_mid_reset();
    int seq[6] = '{15, 0, 3, 9, 1, 6};
    restart(14, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, seq[i], 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || wrap_cnt !== 8'd1 || overflow !== 1'b1 || evt_code !== 2'b00) begin
      errors++;
      $display("FAIL pre_reset: got v=%0b wrap=%0d ovf=%0b c=%0d, want v=1 wrap=1 ovf=1 c=0",
               evt_valid, wrap_cnt, overflow, evt_code);
    end
    drive(1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b0 || wrap_cnt !== 8'd0 || overflow !== 1'b0 ||
        evt_code !== 2'b00 || evt_value !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: got v=%0b wrap=%0d ovf=%0b c=%0d val=%0d, want all 0",
               evt_valid, wrap_cnt, overflow, evt_code, evt_value);
    end
    drive(1'b1, 12, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 13, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL prime_quiet: valid=%0b, want 0", evt_valid);
    end
    drive(1'b1, 5, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'b10 || evt_value !== 4'd5) begin
      errors++;
      $display("FAIL post_prime_err: got v=%0b c=%0d val=%0d, want v=1 c=2 val=5",
               evt_valid, evt_code, evt_value);
    end
  endtask

  task automatic test_wrap_saturate();
    restart(15, 1'b1);
    for (int i = 1; i <= 130; i++) begin
      drive(1'b1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 15, 1'b0, 1'b1, 1'b1, 1'b0);
      if (i == 10) begin
        checks++;
        if (wrap_cnt !== 8'd20) begin
          errors++; $display("FAIL wrap_count: got %0d, want 20", wrap_cnt);
        end
      end
    end
    checks++;
    if (wrap_cnt !== 8'd255 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_saturate: got wrap=%0d ovf=%0b, want wrap=255 ovf=0", wrap_cnt, overflow);
    end
  endtask

  task automatic test_random();
    int  last_c = 4;
    bit  d = 1'b1;
    int  hold_left = 0;
    int  c;
    int  r;
    bit  rst_b;
    restart(last_c, d);
    for (int n = 0; n < 700; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) == 0) d = ~d;
      if (hold_left > 0) begin
        c = last_c; hold_left--;
      end else if (r < 4) begin
        c = last_c; hold_left = $urandom_range(6, 12);
      end else if (r < 50) begin
        c = d ? (last_c + 1) % 16 : (last_c + 15) % 16;
      end else if (r < 75) begin
        c = last_c;
      end else begin
        c = $urandom_range(0, 15);
      end
      rst_b = ($urandom_range(0, 199) != 0);
      drive(rst_b, c, d, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 5);
      last_c = c;
      checks++;
      if (evt_valid !== (mq.size() != 0)) begin
        errors++; $display("FAIL rnd_valid: cycle %0d got %0b, want %0b", n, evt_valid, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        checks++;
        if ({evt_code, evt_value} !== mq[0]) begin
          errors++;
          $display("FAIL rnd_head: cycle %0d got c=%0d val=%0d, want c=%0d val=%0d",
                   n, evt_code, evt_value, mq[0].code, mq[0].value);
        end
      end
      checks++;
      if (wrap_cnt !== 8'(m_wrap) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL rnd_status: cycle %0d got wrap=%0d ovf=%0b, want wrap=%0d ovf=%0b",
                 n, wrap_cnt, overflow, m_wrap, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_step_error();
    test_stall();
    test_overflow();
    test_mid_reset();
    test_wrap_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Sits directly downstream of the up/down counter (`Count`). It samples the counter's output value and direction select every clock.
- Classifies each transition: wrap-up, wrap-down, illegal step, or stall.
- Queues event records in a small FIFO with a valid/ready output, so a slower consumer (logger/checker) can drain them.
- Keeps a saturating wrap tally and a sticky overflow flag for dropped events.

Parameters:
- W, 4, counter value width (matches counter width `w`)
- DEPTH, 4, event FIFO depth; power of 2, ≥2
- STALL_LIM, 8, consecutive unchanged enabled samples that raise a stall event; 1..255

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- cnt_in  in  W  counter output value
- dir  in  1  counter direction (counter's sel): 1=up, 0=down
- cnt_en  in  1  counter expected to advance this cycle
- evt_valid  out  1  FIFO head holds a valid event
- evt_ready  in  1  consumer accepts head when evt_valid=1
- evt_code  out  2  head event type: 00 wrap-up, 01 wrap-down, 10 step error, 11 stall
- evt_value  out  W  cnt_in sampled when the event was detected
- wrap_cnt  out  8  saturating count of wrap events (both directions)
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset (reset=0 at edge):
  - Clears FIFO pointers/occupancy, prev register, primed flag, stall counter, wrap_cnt, overflow.
  - Outputs: evt_valid=0, evt_code=0, evt_value=0, wrap_cnt=0, overflow=0.
  - Mid-operation reset discards all queued events.
- Priming: the first edge after reset release loads prev<=cnt_in, sets primed, and raises no event.
- Detection (combinational on cnt_in, prev, dir, primed=1); exp = dir ? prev+1 : prev-1, modulo 2^W:
  - cnt_in==prev: no transition event; stall counter logic applies.
  - cnt_in==exp, dir=1, prev==2^W-1: wrap-up (00).
  - cnt_in==exp, dir=0, prev==0: wrap-down (01).
  - cnt_in==exp otherwise: legal step, no event.
  - cnt_in!=prev and cnt_in!=exp: step error (10).
  - Categories are mutually exclusive, so at most one event per cycle.
  - prev<=cnt_in every primed cycle.
- Stall:
  - 8-bit stall counter increments when cnt_en=1 and cnt_in==prev.
  - It holds when cnt_en=0 and clears to 0 on any change of cnt_in.
  - Stall event (11) fires on the edge where the counter reaches STALL_LIM. The counter then saturates at STALL_LIM, with no repeat until cnt_in changes.
- FIFO:
  - A detected event is written at the same edge; evt_valid rises the following cycle (1-cycle latency).
  - Pop occurs when evt_valid & evt_ready; the head advances next edge.
  - Order is strictly first-in first-out.
  - Push while full without a simultaneous pop: event dropped, overflow<=1.
  - Push and pop in the same cycle while full: both occur, no drop.
  - Push and pop while empty: push only (no pop, valid was 0).
  - evt_code/evt_value are driven from the head entry. They hold stable while evt_valid=1 and evt_ready=0.
- wrap_cnt: increments on every wrap event (including dropped ones) and saturates at 255.
- overflow: set on drop, cleared by clr_ovf. If a drop and clr_ovf occur in the same cycle, set wins.
- No combinational path from evt_ready to evt_valid.

Test Plan:
1. W=4, dir=1, cnt_en=1, cnt_in 0,1,…,15,0 one per cycle, evt_ready=1 → exactly one event, code 00 value 0, evt_valid high one cycle after the 15→0 sample; wrap_cnt=1.
2. dir=0, cnt_in 3,2,1,0,15 → one event code 01 value 15; wrap_cnt increments by 1; no other events.
3. dir=1, cnt_in 5 then 9 → code 10 value 9. Then dir=0, cnt_in 9 then 10 → code 10 value 10.
4. cnt_en=1, cnt_in held at 7 for 12 cycles after priming → single code 11 value 7 on the 8th equal sample, none afterwards. Changing to 8 then holding 8 cycles → second stall event value 8.
5. evt_ready=0, inject 5 step errors → 4 entries queued, overflow=1. Raise evt_ready → values drain in injection order, evt_valid drops after the 4th. Pulse clr_ovf → overflow=0.
6. Two events queued, reset=0 for one cycle → evt_valid=0, wrap_cnt=0, overflow=0 next cycle. The first post-reset sample (e.g. 12 after prior 3) raises no event.
